// File: rtl/event_stream_scheduler_if.sv
// Bus bundle for the event stream scheduler: the source, time-tag and merged
// output handshakes, plus the period strobe, stall and diagnostic counters.
// The master modport is the scheduler's view. The slave modport is the
// surrounding front-end's view.
interface event_stream_scheduler_if #(
  parameter int DATA_BITS = 128,
  parameter int NUM_SRC   = 4,
  parameter int CNT_BITS  = 16
);
  logic                               period_done;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [NUM_SRC-1:0][DATA_BITS-1:0]  src_data;
  logic                               tt_valid;
  logic                               tt_ready;
  logic [DATA_BITS-1:0]               tt_data;
  logic                               stall;
  logic                               out_valid;
  logic                               out_ready;
  logic [DATA_BITS-1:0]               out_data;
  logic [CNT_BITS-1:0]                overrun_cnt;
  logic [CNT_BITS-1:0]                timeout_cnt;

  modport master (
    input  period_done, src_valid, src_data, tt_valid, tt_data, out_ready,
    output src_ready, tt_ready, stall, out_valid, out_data, overrun_cnt, timeout_cnt
  );

  modport slave (
    output period_done, src_valid, src_data, tt_valid, tt_data, out_ready,
    input  src_ready, tt_ready, stall, out_valid, out_data, overrun_cnt, timeout_cnt
  );
endinterface

// File: rtl/event_stream_scheduler.sv
// Event stream scheduler.
// Merges the per-block event streams and the per-period time tag into one
// registered output stream. At each period boundary the scheduler works in
// three steps:
//   1. Drain the words that were already valid when the period ended.
//   2. Emit exactly one time tag.
//   3. Resume round-robin service of all sources.
module event_stream_scheduler #(
  parameter int DATA_BITS     = 128,
  parameter int NUM_SRC       = 4,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int TAG_TIMEOUT   = 64,
  parameter int CNT_BITS      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  event_stream_scheduler_if.master bus
);
  localparam int PTR_BITS = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TMR_MAX  = (DRAIN_TIMEOUT > TAG_TIMEOUT) ? DRAIN_TIMEOUT : TAG_TIMEOUT;
  localparam int TMR_BITS = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TAG} state_e;

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [PTR_BITS-1:0]  rr_ptr_q;
  logic [TMR_BITS-1:0]  timer_q, timer_d;
  logic                 out_valid_q;
  logic [DATA_BITS-1:0] out_data_q;
  logic [CNT_BITS-1:0]  overrun_q, timeout_q;

  logic [NUM_SRC-1:0]   eligible, req, src_rdy;
  logic [PTR_BITS-1:0]  gnt_idx;
  logic                 gnt_found, slot_free, src_gnt, tt_rdy, tt_xfer;
  logic                 timeout_inc, overrun_inc;

  function automatic logic [PTR_BITS-1:0] wrap(input int v);
    return PTR_BITS'(v % NUM_SRC);
  endfunction

  // Round-robin arbitration among eligible sources, starting at rr_ptr.
  // Produces the one-hot source accept and the time-tag accept.
  always_comb begin
    eligible  = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    case (state_q)
      S_RUN:   eligible = '1;
      S_DRAIN: eligible = pending_q;
      default: eligible = '0;
    endcase
    req = bus.src_valid & eligible;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!gnt_found && req[wrap(int'(rr_ptr_q) + k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap(int'(rr_ptr_q) + k);
      end
    end
    slot_free = ~out_valid_q | bus.out_ready;
    src_gnt   = gnt_found & slot_free;
    src_rdy   = src_gnt ? (NUM_SRC'(1) << gnt_idx) : '0;
    tt_rdy    = (state_q == S_TAG) & slot_free;
    tt_xfer   = tt_rdy & bus.tt_valid;
  end

  // Period sequencing: next state, pending mask and timeout timer.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    timer_d     = timer_q;
    timeout_inc = 1'b0;
    overrun_inc = bus.period_done & (state_q != S_RUN);
    case (state_q)
      S_RUN: begin
        if (bus.period_done) begin
          state_d   = S_DRAIN;
          pending_d = bus.src_valid;
          timer_d   = '0;
        end
      end
      S_DRAIN: begin
        // A source that drops valid has finished its old-period words.
        pending_d = pending_q & bus.src_valid;
        timer_d   = timer_q + 1'b1;
        if (pending_d == '0) begin
          state_d = S_TAG;
          timer_d = '0;
        end else if (timer_q == TMR_BITS'(DRAIN_TIMEOUT - 1)) begin
          timeout_inc = 1'b1;
          pending_d   = '0;
          state_d     = S_TAG;
          timer_d     = '0;
        end
      end
      S_TAG: begin
        timer_d = timer_q + 1'b1;
        if (tt_xfer) begin
          state_d = S_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_BITS'(TAG_TIMEOUT - 1)) begin
          timeout_inc = 1'b1;
          state_d     = S_RUN;
          timer_d     = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // State registers, output stage, round-robin pointer and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= '0;
      timeout_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      if (src_gnt) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.src_data[gnt_idx];
        rr_ptr_q    <= wrap(int'(gnt_idx) + 1);
      end else if (tt_xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.tt_data;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (overrun_inc && overrun_q != '1) overrun_q <= overrun_q + 1'b1;
      if (timeout_inc && timeout_q != '1) timeout_q <= timeout_q + 1'b1;
    end
  end

  assign bus.src_ready   = src_rdy;
  assign bus.tt_ready    = tt_rdy;
  assign bus.stall       = (state_q != S_TAG);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.overrun_cnt = overrun_q;
  assign bus.timeout_cnt = timeout_q;
endmodule

// File: tb/tb_event_stream_scheduler.sv
// Self-checking bench for event_stream_scheduler.
// Starts with a table of per-cycle vectors, then runs hand-written sequences
// for the drain timeout, tag timeout, overrun and mid-operation reset cases.
module tb_event_stream_scheduler;
  localparam int DB = 128;
  localparam int NS = 4;
  localparam int CB = 16;
  localparam logic [DB-1:0] TAG = {4{32'h7A6_0F00}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  event_stream_scheduler_if #(.DATA_BITS(DB), .NUM_SRC(NS), .CNT_BITS(CB)) bus ();

  event_stream_scheduler #(
    .DATA_BITS(DB), .NUM_SRC(NS), .DRAIN_TIMEOUT(1024), .TAG_TIMEOUT(64), .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pd;
    logic [3:0] sv;
    logic       tv;
    logic       ordy;
    logic [3:0] e_sr;
    logic       e_tr;
    logic       e_stall;
    logic       e_ov;
    int         e_sel;
  } vec_t;

  function automatic logic [DB-1:0] word(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {4{w}};
  endfunction

  function automatic logic [DB-1:0] exp_word(input int sel);
    return (sel == 4) ? TAG : word(sel);
  endfunction

  task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.period_done = 1'b0;
    bus.src_valid   = '0;
    bus.tt_valid    = 1'b0;
    bus.out_ready   = 1'b1;
  endtask

  // Returns at one time unit after a rising edge, with the DUT in RUN.
  task automatic do_reset();
    rst = 1'b0;
    clr_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[19];

  initial begin
    int n;
    int tags;
    logic seen_ov;

    vt[0]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 0};
    vt[1]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 2};
    vt[2]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 0};
    vt[3]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 2};
    vt[4]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    vt[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    vt[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4};
    vt[7]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    vt[8]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1};
    vt[9]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1};
    vt[10] = '{1'b0, 4'b1010, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1};
    vt[11] = '{1'b0, 4'b1010, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1};
    vt[12] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    vt[13] = '{1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4};
    vt[14] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 3};
    vt[15] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    vt[16] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 0};
    vt[17] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 0};
    vt[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 0};

    for (int i = 0; i < NS; i++) bus.src_data[i] = word(i);
    bus.tt_data = TAG;
    clr_inputs();
    bus.out_ready = 1'b0;

    // Values while reset is held, before any clock edge.
    #2;
    chk("rst_out_valid", DB'(bus.out_valid), DB'(0));
    chk("rst_out_data",  bus.out_data, '0);
    chk("rst_stall",     DB'(bus.stall), DB'(1));
    chk("rst_src_ready", DB'(bus.src_ready), DB'(0));
    chk("rst_tt_ready",  DB'(bus.tt_ready), DB'(0));
    chk("rst_overrun",   DB'(bus.overrun_cnt), DB'(0));
    chk("rst_timeout",   DB'(bus.timeout_cnt), DB'(0));
    do_reset();

    // Table-driven vectors, one per clock cycle.
    for (int v = 0; v < 19; v++) begin
      bus.period_done = vt[v].pd;
      bus.src_valid   = vt[v].sv;
      bus.tt_valid    = vt[v].tv;
      bus.out_ready   = vt[v].ordy;
      #1;
      chk($sformatf("v%0d_src_ready", v), DB'(bus.src_ready), DB'(vt[v].e_sr));
      chk($sformatf("v%0d_tt_ready", v),  DB'(bus.tt_ready),  DB'(vt[v].e_tr));
      chk($sformatf("v%0d_stall", v),     DB'(bus.stall),     DB'(vt[v].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", v), DB'(bus.out_valid), DB'(vt[v].e_ov));
      if (vt[v].e_ov) chk($sformatf("v%0d_out_data", v), bus.out_data, exp_word(vt[v].e_sel));
    end
    chk("tbl_overrun", DB'(bus.overrun_cnt), DB'(0));
    chk("tbl_timeout", DB'(bus.timeout_cnt), DB'(0));

    // Drain timeout: source 0 never drops valid, so the tag is forced after 1024 cycles.
    do_reset();
    bus.src_valid   = 4'b0001;
    bus.period_done = 1'b1;
    @(posedge clk);
    #1;
    bus.period_done = 1'b0;
    n = 0;
    while (bus.stall && n < 3000) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("drain_cycles", DB'(n), DB'(1024));
    chk("drain_timeout_cnt", DB'(bus.timeout_cnt), DB'(1));
    chk("drain_tag_no_src", DB'(bus.src_ready), DB'(0));
    bus.tt_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tt_valid  = 1'b0;
    bus.src_valid = '0;
    chk("drain_tag_valid", DB'(bus.out_valid), DB'(1));
    chk("drain_tag_data", bus.out_data, TAG);
    chk("drain_back_run", DB'(bus.stall), DB'(1));

    // Tag timeout: the time-tag generator never offers a tag.
    do_reset();
    bus.period_done = 1'b1;
    @(posedge clk);
    #1;
    bus.period_done = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
    seen_ov = 1'b0;
    while (!bus.stall && n < 500) begin
      n++;
      if (bus.out_valid) seen_ov = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("tag_cycles", DB'(n), DB'(64));
    chk("tag_timeout_cnt", DB'(bus.timeout_cnt), DB'(1));
    chk("tag_no_output", DB'(seen_ov | bus.out_valid), DB'(0));

    // Second period_done while draining: counted as an overrun, still only one tag.
    do_reset();
    bus.src_valid   = 4'b0001;
    bus.period_done = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.period_done = 1'b0;
    bus.src_valid   = '0;
    bus.tt_valid    = 1'b1;
    tags = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && bus.out_data == TAG) tags++;
    end
    bus.tt_valid = 1'b0;
    chk("ovr_overrun_cnt", DB'(bus.overrun_cnt), DB'(1));
    chk("ovr_tag_count", DB'(tags), DB'(1));
    chk("ovr_timeout_cnt", DB'(bus.timeout_cnt), DB'(0));

    // Asynchronous reset while a word is stuck in the output stage during TAG.
    do_reset();
    bus.out_ready = 1'b0;
    bus.src_valid = 4'b0001;
    @(posedge clk);
    #1;
    bus.src_valid   = '0;
    bus.period_done = 1'b1;
    @(posedge clk);
    #1;
    bus.period_done = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_pre_stall", DB'(bus.stall), DB'(0));
    chk("arst_pre_ov", DB'(bus.out_valid), DB'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ov", DB'(bus.out_valid), DB'(0));
    chk("arst_stall", DB'(bus.stall), DB'(1));
    chk("arst_tt_ready", DB'(bus.tt_ready), DB'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.src_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("arst_rr_ptr", DB'(bus.src_ready), DB'(4'b0001));
    @(posedge clk);
    #1;
    chk("arst_first_word", bus.out_data, word(0));
    bus.src_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/event_stream_scheduler.md
Name: event_stream_scheduler

Overview:
- Merges the per-block event streams and the per-period time-tag stream of one front-end module into a single 128-bit output stream toward the serializer/link.
- Sequences each period boundary in three steps: drain the previous period's events, emit exactly one time tag, then resume events.
- Drives the time-tag generator's stall input so the tag is held until the drain finishes.

Parameters:
- DATA_BITS, 128, width of every data word
- NUM_SRC, 4, number of event sources (one per block)
- DRAIN_TIMEOUT, 1024, maximum cycles spent in DRAIN before forcing the time tag
- TAG_TIMEOUT, 64, maximum cycles spent in TAG waiting for tt_valid
- CNT_BITS, 16, width of the diagnostic counters

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- period_done  input  1  one-cycle pulse at each period boundary, from the timer
- src_valid  input  NUM_SRC  per-source word valid
- src_ready  output  NUM_SRC  per-source accept, one-hot or zero
- src_data  input  NUM_SRC*DATA_BITS  source words; source i occupies bits [i*DATA_BITS +: DATA_BITS]
- tt_valid  input  1  time tag valid, from the time-tag generator
- tt_ready  output  1  time tag accept
- tt_data  input  DATA_BITS  time tag word
- stall  output  1  hold-off to the time-tag generator
- out_valid  output  1  merged stream valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_BITS  merged stream word
- overrun_cnt  output  CNT_BITS  count of period_done pulses ignored (not in RUN); saturates
- timeout_cnt  output  CNT_BITS  count of DRAIN or TAG timeouts; saturates

Behaviour:
- Reset (rst=0, asynchronous) sets the following; all take effect immediately and hold until the first clk edge after release:
  - state=RUN
  - out_valid=0, out_data=0
  - src_ready=0, tt_ready=0
  - stall=1
  - pending=0, rr_ptr=0, timer=0
  - overrun_cnt=0, timeout_cnt=0
- Output register: one stage. slot_free = ~out_valid | out_ready.
  - A transfer loads out_data and sets out_valid on the next edge, giving 1-cycle latency from handshake to out_valid.
  - out_valid clears when out_ready=1 and no new load happens in the same cycle.
- src_ready and tt_ready are combinational from state, pending, rr_ptr, src_valid and slot_free. At most one of src_ready/tt_ready is high in any cycle.
- Round-robin arbitration over eligible valid sources:
  - Search starts at rr_ptr and wraps modulo NUM_SRC.
  - After a grant to source i, rr_ptr = (i+1) mod NUM_SRC.
- State RUN:
  - stall=1; eligible = all sources.
  - On period_done: pending <= src_valid, timer <= 0, go to DRAIN.
  - A grant in the same cycle as period_done is still honoured. That source's pending bit is taken from the sampled src_valid.
- State DRAIN:
  - stall=1; eligible = sources with a pending bit set. Sources not pending hold new-period data and are not granted.
  - A pending bit clears in any cycle where that source's src_valid=0.
  - When pending==0, go to TAG with timer <= 0. Sources that were not valid at period_done make this a zero-extra-cycle pass.
  - When timer reaches DRAIN_TIMEOUT-1: increment timeout_cnt, clear pending, go to TAG.
- State TAG:
  - stall=0; no source is eligible.
  - tt_ready = slot_free. On tt_valid & tt_ready, load tt_data and go to RUN.
  - When timer reaches TAG_TIMEOUT-1 with no transfer: increment timeout_cnt, go to RUN.
- period_done while in DRAIN or TAG: ignored, overrun_cnt increments. The current sequence continues and no second tag is forced.
- Counters saturate at all-ones.
- Backpressure: with out_ready=0 and out_valid=1, no handshakes occur. The timer still advances, so timeouts remain the guaranteed exit.
- Reset mid-operation: all state is discarded, and the output word is dropped without being presented.

Test Plan:
- Sources 0 and 2 continuously valid in RUN with out_ready=1 -> grants alternate 0,2,0,2; out_valid follows each handshake by 1 cycle; no gaps.
- period_done with only source 1 valid, which then sends 3 more words and drops valid; source 3 raises valid 2 cycles later -> all 1's words precede the tag; the tag precedes any word from 3; stall falls the cycle after src_valid[1]=0.
- period_done with no sources valid and tt_valid asserted the following cycle -> out_data = tt_data exactly one word; state returns to RUN; stall=1 again.
- Source 0 held valid through DRAIN for 1024 cycles -> TAG is entered at cycle 1024; timeout_cnt=1; the tag is emitted.
- In TAG, tt_valid held 0 for 64 cycles -> RUN resumes; timeout_cnt=1; no tag is emitted.
- Second period_done during DRAIN -> overrun_cnt=1; only one tag is emitted.
- rst=0 pulsed while out_valid=1 and out_ready=0 -> out_valid=0 and stall=1 immediately, without waiting for clk; after release, RUN resumes with rr_ptr=0.
